// File: rtl/bcd_down_timer.sv
// Loadable, pausable BCD countdown timer with done and load-error pulses.
// Optional BCD_TIMER_AUTO_RELOAD_EN: restart from the last loaded preset.
module bcd_down_timer #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   out,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [W-1:0] reload;
`endif

    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Digit-wise borrow chain; never produces non-BCD intermediates.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out      <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            reload   <= '0;
`endif
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (load && is_bcd(load_val)) begin
                out   <= load_val;
                state <= IDLE;
                busy  <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                reload <= load_val;
`endif
            end else begin
                // A rejected load flags the error but lets the FSM proceed.
                if (load) load_err <= 1'b1;
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (out != '0) begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                        end else if (out == '0) begin
                            out <= reload;
`endif
                        end else begin
                            out <= bcd_dec(out);
                            if (out == ONE) begin
                                done <= 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                                if (reload == '0) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
`else
                                state <= IDLE;
                                busy  <= 1'b0;
`endif
                            end
                        end
                    end
                    PAUSE: begin
                        if (start) state <= RUN;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer (DIGITS=2).
// Auto-reload expectations follow BCD_TIMER_AUTO_RELOAD_EN when defined.
module tb_bcd_down_timer;

    logic       clk;
    logic       rstn;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       load_err;

    int checks;
    int fails;

    bcd_down_timer #(.DIGITS(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int e);
        return {4'(e / 10), 4'(e % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_init out=%h busy=%b done=%b err=%b want 00/0/0/0",
                     out, busy, done, load_err);
        end
        tick();
        rstn = 1'b1;
        tick();
        do_load(8'h40);
        do_start();
        tick();
        tick();
        tick();
        checks++;
        if (out !== 8'h37 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre out=%h busy=%b want 37/1", out, busy);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_async out=%h busy=%b done=%b want 00/0/0",
                     out, busy, done);
        end
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_after out=%h busy=%b done=%b want 00/0/0",
                     out, busy, done);
        end
    endtask

    task automatic test_basic();
        do_load(8'h12);
        checks++;
        if (out !== 8'h12 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_load out=%h busy=%b want 12/0", out, busy);
        end
        do_start();
        checks++;
        if (out !== 8'h12 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_start out=%h busy=%b want 12/1", out, busy);
        end
        for (int e = 11; e >= 0; e--) begin
            tick();
            checks++;
            if (out !== to_bcd(e) || done !== (e == 0) || busy !== (e != 0)) begin
                fails++;
                $display("FAIL basic_seq out=%h done=%b busy=%b want %h/%0d/%0d",
                         out, done, busy, to_bcd(e), e == 0, e != 0);
            end
        end
        tick();
        checks++;
        if (out !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_end out=%h done=%b busy=%b want 00/0/0",
                     out, done, busy);
        end
    endtask

    task automatic test_borrow();
        do_load(8'h20);
        do_start();
        tick();
        checks++;
        if (out !== 8'h19) begin
            fails++;
            $display("FAIL borrow_19 out=%h want 19", out);
        end
        tick();
        checks++;
        if (out !== 8'h18) begin
            fails++;
            $display("FAIL borrow_18 out=%h want 18", out);
        end
        start = 1'b1;
        do_load(8'h00);
        checks++;
        if (out !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_load out=%h done=%b busy=%b want 00/0/0",
                     out, done, busy);
        end
        tick();
        start = 1'b0;
        checks++;
        if (out !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_start out=%h done=%b busy=%b want 00/1/0",
                     out, done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_pulse done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_pause();
        do_load(8'h09);
        pause = 1'b1;
        tick();
        checks++;
        if (out !== 8'h09 || busy !== 1'b0) begin
            fails++;
            $display("FAIL pause_idle out=%h busy=%b want 09/0", out, busy);
        end
        pause = 1'b0;
        do_start();
        tick();
        tick();
        tick();
        checks++;
        if (out !== 8'h06) begin
            fails++;
            $display("FAIL pause_pre out=%h want 06", out);
        end
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out !== 8'h06 || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL pause_hold out=%h busy=%b want 06/1", out, busy);
            end
        end
        start = 1'b1;
        tick();
        pause = 1'b0;
        start = 1'b0;
        checks++;
        if (out !== 8'h06 || busy !== 1'b1) begin
            fails++;
            $display("FAIL resume_edge out=%h busy=%b want 06/1", out, busy);
        end
        tick();
        checks++;
        if (out !== 8'h05) begin
            fails++;
            $display("FAIL resume_05 out=%h want 05", out);
        end
        tick();
        checks++;
        if (out !== 8'h04) begin
            fails++;
            $display("FAIL resume_04 out=%h want 04", out);
        end
    endtask

    task automatic test_invalid_load();
        do_load(8'h10);
        do_start();
        tick();
        tick();
        tick();
        checks++;
        if (out !== 8'h07) begin
            fails++;
            $display("FAIL inv_pre out=%h want 07", out);
        end
        do_load(8'h3A);
        checks++;
        if (out !== 8'h06 || load_err !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL inv_load out=%h err=%b busy=%b want 06/1/1",
                     out, load_err, busy);
        end
        tick();
        checks++;
        if (out !== 8'h05 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL inv_after out=%h err=%b want 05/0", out, load_err);
        end
        do_load(8'h45);
        checks++;
        if (out !== 8'h45 || busy !== 1'b0 || done !== 1'b0 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL abort_load out=%h busy=%b done=%b err=%b want 45/0/0/0",
                     out, busy, done, load_err);
        end
        tick();
        checks++;
        if (out !== 8'h45 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_hold out=%h busy=%b done=%b want 45/0/0",
                     out, busy, done);
        end
    endtask

    task automatic test_terminal();
        do_load(8'h03);
        do_start();
        for (int e = 2; e >= 0; e--) begin
            tick();
            checks++;
            if (out !== to_bcd(e) || done !== (e == 0)) begin
                fails++;
                $display("FAIL term_seq out=%h done=%b want %h/%0d",
                         out, done, to_bcd(e), e == 0);
            end
        end
        tick();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        checks++;
        if (out !== 8'h03 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL reload out=%h busy=%b done=%b want 03/1/0",
                     out, busy, done);
        end
        for (int e = 2; e >= 0; e--) begin
            tick();
            checks++;
            if (out !== to_bcd(e) || done !== (e == 0)) begin
                fails++;
                $display("FAIL reload_seq out=%h done=%b want %h/%0d",
                         out, done, to_bcd(e), e == 0);
            end
        end
        do_load(8'h00);
`else
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL term_idle out=%h busy=%b done=%b want 00/0/0",
                     out, busy, done);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        rstn     = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        start    = 1'b0;
        pause    = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_pause();
        test_invalid_load();
        test_terminal();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Loadable, pausable multi-digit BCD down-counter (countdown timer).
- Complements the team's mod-10 up-counters: it consumes a BCD preset, counts to zero, and signals completion.
- Sits in the timing/stopwatch datapath.
- Its BCD output drives the same 7-segment/display decoders as the up-counters.

Parameters:
- DIGITS, 2, number of BCD digits; count width is 4*DIGITS bits, least-significant digit in bits [3:0].

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- load  input  1  load request, sampled on rising edge
- load_val  input  4*DIGITS  BCD preset value
- start  input  1  start/resume request, level sampled each edge
- pause  input  1  pause request, level sampled each edge
- out  output  4*DIGITS  current BCD count (registered)
- busy  output  1  high in RUN or PAUSE
- done  output  1  one-cycle pulse, count reached zero
- load_err  output  1  one-cycle pulse, load rejected (non-BCD digit)

Behaviour:
- One clock (clk); reset rstn is asynchronous, active-low.
- Reset values: out=0, state=IDLE, busy=0, done=0, load_err=0, reload register=0.
- All outputs are registered. done and load_err are high for exactly one cycle per event.
- States:
  - IDLE: holding, not counting.
  - RUN: decrement once per clock.
  - PAUSE: holding mid-count.
- Priority per edge: load > pause (in RUN) > start > count.
- load with every digit <= 9:
  - out<=load_val, reload register<=load_val, state->IDLE, from any state.
  - Aborts a running count; no done pulse.
- load with any digit > 9:
  - load_err=1 next cycle.
  - out, state and reload register unchanged.
  - Counting continues if in RUN.
- IDLE transitions:
  - start with out!=0 -> RUN. First decrement on the following edge.
  - start with out==0 -> done pulse, stay IDLE.
  - pause is ignored.
- RUN transitions:
  - pause -> PAUSE; out holds its value that edge.
  - Otherwise out decrements by 1 in BCD.
- BCD decrement rule:
  - A digit at 0 becomes 9 and borrows from the next digit.
  - Other digits decrement only on borrow; no binary intermediate values are allowed.
- Terminal count in RUN: the edge where out goes from 0..01 to 0 sets done=1 in that same cycle (out already shows 0) and state->IDLE.
- Timing: load 5, start sampled at edge k -> out=4 after edge k+1, out=0 and done=1 after edge k+5.
- PAUSE transitions:
  - start -> RUN; decrement resumes the next edge. start+pause together also resumes.
  - pause alone keeps PAUSE.
- busy = (state==RUN || state==PAUSE).
- Reset asserted mid-count clears everything immediately. No done pulse is produced.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - At terminal count, out goes to 0 and done pulses, but state stays RUN.
  - On the next edge out<=reload register (no decrement that edge). Counting continues, giving a period of N+1 cycles.
  - If the reload register is 0, it goes to IDLE as normal.
  - pause/load behave as above.
- Not defined: no reload register is synthesized. Terminal count always returns to IDLE.

Test Plan:
- Reset: rstn=0 mid-count at out=37 -> out=00, busy=0, done=0 immediately, without a clock edge.
- Basic count: load 12, start one cycle -> out sequence 12,11,10,09,...,01,00. done=1 only with 00, then busy=0.
- Digit borrow (DIGITS=2): load 20, start -> 20,19,18. Load 00 with start -> done pulse, out stays 00, busy=0.
- Pause/resume: load 09, start, pause high after out=06 -> out holds 06 for 5 cycles with busy=1. Then start -> 05,04,...
- Invalid load: load 3A during RUN at out=07 -> load_err pulse, counting continues 06,05. Valid load 45 during RUN -> out=45, IDLE, no done.
- With BCD_TIMER_AUTO_RELOAD_EN: load 03, start -> 03,02,01,00(done),03,02,01,00(done)... Without the macro -> stops at 00, IDLE.
